fb_ocm_writer: RTL and testbench
================================

FB_OCM_WRITER -- requirements
Module: fb_ocm_writer

Interface
REQ-001 Clk  input  1  system clock; all state changes on its rising edge.
REQ-002 Reset  input  1  synchronous, active-high reset, sampled on Clk rising edge.
REQ-003 writing  input  1  word-write request from the background loader; one-cycle pulse or level.
REQ-004 addr_OCM  input  19  frame-buffer word index; one word is 2 pixels.
REQ-005 DATA_IN  input  16  pixel pair: [15:8] first pixel, [7:0] second pixel.
REQ-006 vga_rd_req  input  1  display-side byte read request; highest priority.
REQ-007 vga_rd_addr  input  19  display-side byte address.
REQ-008 ocm_q  input  8  OCM read data, valid one cycle after the address is presented.
REQ-009 ocm_addr  output  19  OCM byte address.
REQ-010 ocm_we  output  1  OCM byte write enable.
REQ-011 ocm_d  output  8  OCM write data.
REQ-012 vga_rd_data  output  8  display read data.
REQ-013 vga_rd_valid  output  1  vga_rd_data is valid.
REQ-014 OCM_done  output  1  one-cycle pulse when both bytes of the accepted word are written.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 addr_err  output  1  sticky flag: a request had addr_OCM >= FB_WORDS.
REQ-017 overrun  output  1  sticky flag: writing was high while busy.
REQ-018 frame_done  output  1  high once FB_WORDS words have been written since the last Reset.

Function
REQ-019 The block SHALL implement the states IDLE, WR_HI, WR_LO and DONE.
REQ-020 In IDLE with writing=1 and addr_OCM < 153600, the block SHALL latch addr_OCM and DATA_IN and go to WR_HI next cycle.
REQ-021 In IDLE with writing=1 and addr_OCM >= 153600, the block SHALL set addr_err, write nothing, and stay in IDLE.
REQ-022 In WR_HI without vga_rd_req, the block SHALL drive ocm_we=1, ocm_addr={word,1'b0} and ocm_d=data[15:8], then go to WR_LO.
REQ-023 In WR_LO without vga_rd_req, the block SHALL drive ocm_we=1, ocm_addr={word,1'b1} and ocm_d=data[7:0], then go to DONE.
REQ-024 Byte address arithmetic SHALL be 19-bit with no wrap; the maximum legal byte address is 307199.
REQ-025 When vga_rd_req=1 in any state, the block SHALL drive ocm_we=0 and ocm_addr=vga_rd_addr, and a WR_HI or WR_LO state SHALL hold (stall) for that cycle.
REQ-026 The cycle after a read request, the block SHALL drive vga_rd_valid=1 and vga_rd_data=ocm_q.
REQ-027 In DONE, the block SHALL assert OCM_done for exactly one cycle, increment the 18-bit word counter, and return to IDLE.
REQ-028 With no contention, the latency SHALL be 3 cycles: writing at cycle N, high byte at N+1, low byte at N+2, OCM_done at N+3.
REQ-029 A writing=1 seen in WR_HI, WR_LO or DONE SHALL be dropped and SHALL set overrun; the in-flight word SHALL be unaffected.
REQ-030 The block SHALL set frame_done when the word counter reaches 153600; the counter SHALL saturate and frame_done SHALL stay set.
REQ-031 When not writing, the block SHALL drive ocm_we=0 and ocm_d=0.

Reset
REQ-032 On Reset, the block SHALL set the state to IDLE and clear: word counter, latched word and data, OCM_done, vga_rd_valid, vga_rd_data, addr_err, overrun, frame_done, ocm_we, ocm_addr and ocm_d.
REQ-033 Reset during WR_HI or WR_LO SHALL abandon the word: no further byte is written and no OCM_done is issued.

Structure
REQ-034 Shared package fb_pkg SHALL hold: FB_WIDTH=640, FB_HEIGHT=480, FB_BYTES=307200, FB_WORDS=153600, and the state enum fb_wr_state_t.
REQ-035 The RTL SHALL be a single module; the bench SHALL use the model ocm_fb_ram (single-port, 307200x8, 1-cycle read).

Verification
REQ-036 Single write: writing at addr 5, data 16'hA1B2 -> RAM[10]=A1, RAM[11]=B2, OCM_done exactly 3 cycles after request.
REQ-037 Contention: vga_rd_req held for 2 cycles during WR_HI -> the write stalls 2 cycles, OCM_done at N+5, vga_rd_valid follows each read cycle with correct data.
REQ-038 Bad address: writing at addr 153600 -> addr_err=1, no ocm_we, busy stays 0.
REQ-039 Overrun: writing pulsed again at N+1 -> overrun=1, only the first word is written.
REQ-040 Full frame: 153600 sequential words -> frame_done=1 after the last OCM_done, RAM[307199] holds the last low byte.
REQ-041 Reset in WR_LO -> RAM low byte unchanged, no OCM_done, all outputs at reset values next cycle.

Source files
------------

// File: rtl/fb_pkg.sv
// Frame-buffer geometry and writer state encoding shared by the OCM
// writer and anything that needs to reason about frame-buffer addresses.
package fb_pkg;

    localparam int FB_WIDTH  = 640;
    localparam int FB_HEIGHT = 480;
    localparam int FB_BYTES  = 307200;
    localparam int FB_WORDS  = 153600;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_HI = 2'd1,
        WR_LO = 2'd2,
        DONE  = 2'd3
    } fb_wr_state_t;

    // A word index below FB_WORDS fits in 18 bits, so the byte address never wraps.
    function automatic logic [18:0] fb_byte_addr(input logic [17:0] word, input logic lo);
        return {word, lo};
    endfunction

endpackage

// File: rtl/fb_ocm_writer.sv
// Splits 16-bit pixel-pair writes into two byte writes on the single-port OCM,
// yielding the port to display reads whenever they are requested.
module fb_ocm_writer
    import fb_pkg::*;
#(
    parameter int FRAME_WORDS = FB_WORDS
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        writing,
    input  logic [18:0] addr_OCM,
    input  logic [15:0] DATA_IN,
    input  logic        vga_rd_req,
    input  logic [18:0] vga_rd_addr,
    input  logic [7:0]  ocm_q,
    output logic [18:0] ocm_addr,
    output logic        ocm_we,
    output logic [7:0]  ocm_d,
    output logic [7:0]  vga_rd_data,
    output logic        vga_rd_valid,
    output logic        OCM_done,
    output logic        busy,
    output logic        addr_err,
    output logic        overrun,
    output logic        frame_done
);

    localparam logic [17:0] FRAME_CNT = 18'(FRAME_WORDS);

    fb_wr_state_t state_q, state_d;
    logic [17:0]  word_q, word_d;
    logic [15:0]  data_q, data_d;
    logic [17:0]  cnt_q, cnt_d;
    logic         addr_err_q, addr_err_d;
    logic         overrun_q, overrun_d;
    logic         rd_valid_q, rd_valid_d;
    logic         addr_ok;
    logic         accept;

    assign addr_ok = (addr_OCM < 19'(FB_WORDS));
    assign accept  = (state_q == IDLE) && writing && addr_ok;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            word_q     <= '0;
            data_q     <= '0;
            cnt_q      <= '0;
            addr_err_q <= 1'b0;
            overrun_q  <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            addr_err_q <= addr_err_d;
            overrun_q  <= overrun_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // A display read owns the port, so the byte-write states hold while it is asserted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)      state_d = WR_HI;
            WR_HI:   if (!vga_rd_req) state_d = WR_LO;
            WR_LO:   if (!vga_rd_req) state_d = DONE;
            DONE:                     state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    always_comb begin
        word_d     = word_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        addr_err_d = addr_err_q | ((state_q == IDLE) && writing && !addr_ok);
        overrun_d  = overrun_q | (writing && (state_q != IDLE));
        rd_valid_d = vga_rd_req;
        if (accept) begin
            word_d = addr_OCM[17:0];
            data_d = DATA_IN;
        end
        if ((state_q == DONE) && (cnt_q != FRAME_CNT)) begin
            cnt_d = cnt_q + 18'd1;
        end
    end

    // Outputs are gated by Reset so a reset landing mid-word cannot commit the pending byte.
    always_comb begin
        ocm_we   = 1'b0;
        ocm_addr = '0;
        ocm_d    = '0;
        OCM_done = 1'b0;
        if (!Reset) begin
            OCM_done = (state_q == DONE);
            if (vga_rd_req) begin
                ocm_addr = vga_rd_addr;
            end else if (state_q == WR_HI) begin
                ocm_we   = 1'b1;
                ocm_addr = fb_byte_addr(word_q, 1'b0);
                ocm_d    = data_q[15:8];
            end else if (state_q == WR_LO) begin
                ocm_we   = 1'b1;
                ocm_addr = fb_byte_addr(word_q, 1'b1);
                ocm_d    = data_q[7:0];
            end
        end
    end

    assign busy         = (state_q != IDLE);
    assign addr_err     = addr_err_q;
    assign overrun      = overrun_q;
    assign frame_done   = (cnt_q == FRAME_CNT);
    assign vga_rd_valid = rd_valid_q;
    assign vga_rd_data  = rd_valid_q ? ocm_q : 8'd0;

endmodule

// File: tb/tb_fb_ocm_writer.sv
// Directed and randomized bench for fb_ocm_writer with a behavioural
// byte-memory reference and an OCM RAM model (ocm_fb_ram behaviour inline).
module tb_fb_ocm_writer;
    import fb_pkg::*;

    localparam int TB_FRAME = 64;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        writing;
    logic [18:0] addr_OCM;
    logic [15:0] DATA_IN;
    logic        vga_rd_req;
    logic [18:0] vga_rd_addr;
    logic [7:0]  ocm_q;
    logic [18:0] ocm_addr;
    logic        ocm_we;
    logic [7:0]  ocm_d;
    logic [7:0]  vga_rd_data;
    logic        vga_rd_valid;
    logic        OCM_done;
    logic        busy;
    logic        addr_err;
    logic        overrun;
    logic        frame_done;

    always #5 Clk = ~Clk;

    fb_ocm_writer #(.FRAME_WORDS(TB_FRAME)) dut (
        .Clk(Clk), .Reset(Reset), .writing(writing), .addr_OCM(addr_OCM),
        .DATA_IN(DATA_IN), .vga_rd_req(vga_rd_req), .vga_rd_addr(vga_rd_addr),
        .ocm_q(ocm_q), .ocm_addr(ocm_addr), .ocm_we(ocm_we), .ocm_d(ocm_d),
        .vga_rd_data(vga_rd_data), .vga_rd_valid(vga_rd_valid), .OCM_done(OCM_done),
        .busy(busy), .addr_err(addr_err), .overrun(overrun), .frame_done(frame_done)
    );

    // Single-port 307200x8 OCM with one-cycle read latency
    logic [7:0] ram [0:FB_BYTES-1];
    int         we_cnt = 0;
    always @(posedge Clk) begin
        if (ocm_we) begin
            ram[ocm_addr] <= ocm_d;
            we_cnt        <= we_cnt + 1;
        end
        ocm_q <= ram[ocm_addr];
    end

    // Reference: what each frame-buffer byte should hold, and words completed since reset
    logic [7:0] ref_mem [int];
    int         known_q[$];
    int         word_cnt;
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic model_byte(input int a, input logic [7:0] v);
        if (!ref_mem.exists(a)) known_q.push_back(a);
        ref_mem[a] = v;
    endtask

    task automatic model_word(input int w, input logic [15:0] d);
        model_byte(2 * w, d[15:8]);
        model_byte(2 * w + 1, d[7:0]);
        word_cnt++;
    endtask

    task automatic check_word(input string tag, input int w);
        chk({tag, "_hi"}, 32'(ram[2 * w]), 32'(ref_mem[2 * w]));
        chk({tag, "_lo"}, 32'(ram[2 * w + 1]), 32'(ref_mem[2 * w + 1]));
    endtask

    // Issue one word, with nrd display reads starting the cycle after the request.
    task automatic do_write(input string tag, input int w, input logic [15:0] d,
                            input int nrd, input bit check_hi);
        int lat;
        int ra;
        writing  = 1'b1;
        addr_OCM = 19'(w);
        DATA_IN  = d;
        step();
        writing = 1'b0;
        lat     = 1;
        if (check_hi && nrd == 0) begin
            chk({tag, "_hi_we"}, 32'(ocm_we), 32'd1);
            chk({tag, "_hi_addr"}, 32'(ocm_addr), 32'(2 * w));
            chk({tag, "_hi_d"}, 32'(ocm_d), 32'(d[15:8]));
        end
        for (int k = 0; k < nrd; k++) begin
            ra          = known_q[$urandom_range(0, known_q.size() - 1)];
            vga_rd_req  = 1'b1;
            vga_rd_addr = 19'(ra);
            #1;
            chk({tag, "_rd_we"}, 32'(ocm_we), 32'd0);
            chk({tag, "_rd_addr"}, 32'(ocm_addr), 32'(ra));
            step();
            lat++;
            vga_rd_req = 1'b0;
            chk({tag, "_rd_valid"}, 32'(vga_rd_valid), 32'd1);
            chk({tag, "_rd_data"}, 32'(vga_rd_data), 32'(ref_mem[ra]));
        end
        while (OCM_done !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(3 + nrd));
        chk({tag, "_valid_idle"}, 32'(vga_rd_valid), 32'd0);
        model_word(w, d);
        step();
        chk({tag, "_done_pulse"}, 32'(OCM_done), 32'd0);
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'(word_cnt >= TB_FRAME));
        check_word(tag, w);
    endtask

    initial begin
        int w;
        int ra;
        int we0;
        logic [15:0] d;

        Reset       = 1'b1;
        writing     = 1'b0;
        addr_OCM    = '0;
        DATA_IN     = '0;
        vga_rd_req  = 1'b0;
        vga_rd_addr = '0;
        word_cnt    = 0;
        step();
        step();
        Reset = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_we", 32'(ocm_we), 32'd0);
        chk("rst_addr", 32'(ocm_addr), 32'd0);
        chk("rst_d", 32'(ocm_d), 32'd0);
        chk("rst_done", 32'(OCM_done), 32'd0);
        chk("rst_valid", 32'(vga_rd_valid), 32'd0);
        chk("rst_rdata", 32'(vga_rd_data), 32'd0);
        chk("rst_flags", {29'd0, addr_err, overrun, frame_done}, 32'd0);

        do_write("single", 5, 16'hA1B2, 0, 1'b1);
        chk("single_ram10", 32'(ram[10]), 32'hA1);
        chk("single_ram11", 32'(ram[11]), 32'hB2);

        do_write("contend2", 9, 16'h5A6B, 2, 1'b0);

        // Out-of-range request is flagged and leaves the OCM untouched
        we0      = we_cnt;
        writing  = 1'b1;
        addr_OCM = 19'(FB_WORDS);
        DATA_IN  = 16'hDEAD;
        step();
        writing = 1'b0;
        chk("badaddr_err", 32'(addr_err), 32'd1);
        chk("badaddr_busy", 32'(busy), 32'd0);
        step();
        step();
        chk("badaddr_nowrite", 32'(we_cnt), 32'(we0));
        chk("badaddr_overrun", 32'(overrun), 32'd0);

        // Second pulse while the first word is in flight is dropped
        writing  = 1'b1;
        addr_OCM = 19'd100;
        DATA_IN  = 16'h1357;
        step();
        addr_OCM = 19'd5;
        DATA_IN  = 16'hFFFF;
        step();
        writing = 1'b0;
        chk("overrun_flag", 32'(overrun), 32'd1);
        chk("overrun_busy", 32'(busy), 32'd1);
        step();
        chk("overrun_done", 32'(OCM_done), 32'd1);
        model_word(100, 16'h1357);
        step();
        check_word("overrun_first", 100);
        check_word("overrun_second", 5);

        for (int i = 0; i < 8; i++) begin
            w = $urandom_range(0, FB_WORDS - 1);
            d = 16'($urandom);
            do_write("rand_contend", w, d, $urandom_range(0, 3), 1'b1);
        end
        for (int i = 0; i < 16; i++) begin
            w = $urandom_range(0, FB_WORDS - 1);
            d = 16'($urandom);
            do_write("rand_write", w, d, 0, 1'b1);
        end
        for (int i = 0; i < 12; i++) begin
            ra          = known_q[$urandom_range(0, known_q.size() - 1)];
            vga_rd_req  = 1'b1;
            vga_rd_addr = 19'(ra);
            step();
            vga_rd_req = 1'b0;
            chk("idle_rd_valid", 32'(vga_rd_valid), 32'd1);
            chk("idle_rd_data", 32'(vga_rd_data), 32'(ref_mem[ra]));
        end

        // Reset while the low byte is being driven abandons the word
        do_write("pre_reset", 777, 16'h1122, 0, 1'b0);
        writing  = 1'b1;
        addr_OCM = 19'd777;
        DATA_IN  = 16'h3344;
        step();
        writing = 1'b0;
        step();
        chk("wrlo_we", 32'(ocm_we), 32'd1);
        Reset = 1'b1;
        #1;
        chk("wrlo_rst_we", 32'(ocm_we), 32'd0);
        step();
        Reset = 1'b0;
        model_byte(1554, 8'h33);
        word_cnt = 0;
        #1;
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_done", 32'(OCM_done), 32'd0);
        chk("post_rst_out", {4'd0, ocm_we, ocm_addr, ocm_d}, 32'd0);
        chk("post_rst_flags", {29'd0, addr_err, overrun, frame_done}, 32'd0);
        chk("post_rst_valid", 32'(vga_rd_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst_nodone", 32'(OCM_done), 32'd0);
        end
        check_word("reset_wrlo", 777);

        // Frame completion with a reduced frame size, then saturation
        for (int i = 0; i < TB_FRAME; i++) begin
            do_write("frame", i, 16'($urandom), 0, 1'b0);
        end
        chk("frame_done_set", 32'(frame_done), 32'd1);
        do_write("frame_last", FB_WORDS - 1, 16'hBEEF, 0, 1'b1);
        chk("ram_307199", 32'(ram[FB_BYTES - 1]), 32'hEF);
        chk("frame_done_hold", 32'(frame_done), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
